// File: rtl/regheap_drain_64x16b.sv
// Snapshots a 64 x 16b accumulator heap and streams it out as 16 beats of 4 lanes.
// The heap can optionally be cleared in the cycle after capture so it can start accumulating again.
module regheap_drain_64x16b #(
    parameter int CLR_AFTER_LOAD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          snap_req,
    input  logic [1023:0] heap_data,
    input  logic          heap_data_v,
    output logic          heap_clr,
    output logic          busy,
    output logic [63:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [3:0]    out_idx,
    output logic          done
);

    localparam int BEAT_W   = 64;
    localparam int LAST_IDX = 15;

    typedef enum logic [1:0] {IDLE, WAIT, STREAM, DONE} state_t;

    state_t          r_state;
    logic [1023:0]   r_snapshot;
    logic [63:0]     r_out_data;
    logic            r_out_valid;
    logic            r_out_last;
    logic [3:0]      r_out_idx;
    logic            r_heap_clr;
    logic            r_busy;
    logic            r_done;

    state_t          w_state_nxt;
    logic            w_capture;
    logic            w_xfer;
    logic [63:0]     w_data_nxt;
    logic            w_valid_nxt;
    logic            w_last_nxt;
    logic [3:0]      w_idx_nxt;
    logic            w_clr_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_xfer      = r_out_valid && out_ready;
        case (r_state)
            IDLE: begin
                if (snap_req) begin
                    if (heap_data_v) begin
                        w_capture   = 1'b1;
                        w_state_nxt = STREAM;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (heap_data_v) begin
                    w_capture   = 1'b1;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (w_xfer && (r_out_idx == 4'(LAST_IDX)))
                    w_state_nxt = DONE;
            end
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // Index wraps 15 -> 0 naturally on the final handshake.
        w_idx_nxt = r_out_idx;
        if (w_capture)
            w_idx_nxt = 4'd0;
        else if (w_xfer)
            w_idx_nxt = r_out_idx + 4'd1;

        w_valid_nxt = (w_state_nxt == STREAM);

        // First beat comes straight from the heap since the snapshot is loading on the same edge.
        w_data_nxt = r_out_data;
        if (!w_valid_nxt)
            w_data_nxt = '0;
        else if (w_capture)
            w_data_nxt = heap_data[BEAT_W-1:0];
        else if (w_xfer)
            w_data_nxt = r_snapshot[{w_idx_nxt, 6'd0} +: BEAT_W];

        w_last_nxt = w_valid_nxt && (w_idx_nxt == 4'(LAST_IDX));
        w_clr_nxt  = w_capture && (CLR_AFTER_LOAD != 0);
        w_busy_nxt = (w_state_nxt == WAIT) || (w_state_nxt == STREAM);
        w_done_nxt = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_snapshot  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_idx   <= 4'd0;
            r_heap_clr  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            if (w_capture)
                r_snapshot <= heap_data;
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            r_out_idx   <= w_idx_nxt;
            r_heap_clr  <= w_clr_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign heap_clr  = r_heap_clr;
    assign busy      = r_busy;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_idx   = r_out_idx;
    assign done      = r_done;

endmodule

// File: doc/regheap_drain_64x16b.md
REGHEAP_DRAIN_64X16B -- requirements
Module: regheap_drain_64x16b

Interface
REQ-001 The block SHALL run on one clock; reset is asynchronous and active-low.
REQ-002 Parameter CLR_AFTER_LOAD, default 1, SHALL select whether heap_clr is pulsed after each snapshot capture (1 = pulse, 0 = never asserted).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous active-low reset.
REQ-005 Port snap_req  input  1  SHALL request a snapshot-and-drain of the accumulator heap.
REQ-006 Port heap_data  input  1024  SHALL carry 64 x 16b accumulated lanes; lane i in bits [16i+15:16i].
REQ-007 Port heap_data_v  input  1  SHALL qualify heap_data as stable and capturable.
REQ-008 Port heap_clr  output  1  SHALL drive the heap's usr_rst clear input.
REQ-009 Port busy  output  1  SHALL be high while a request is pending or a drain is in progress.
REQ-010 Port out_data  output  64  SHALL carry one beat of 4 lanes.
REQ-011 Port out_valid  output  1  SHALL mark out_data valid.
REQ-012 Port out_ready  input  1  SHALL be the downstream acceptance signal.
REQ-013 Port out_last  output  1  SHALL mark the final beat (index 15).
REQ-014 Port out_idx  output  4  SHALL give the current beat index 0..15.
REQ-015 Port done  output  1  SHALL pulse one cycle after the last beat is accepted.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, STREAM, DONE; all outputs registered.
REQ-017 IDLE: snap_req=1 and heap_data_v=1 at edge N SHALL capture heap_data into a 1024b snapshot register at edge N and enter STREAM.
REQ-018 IDLE: snap_req=1 with heap_data_v=0 SHALL enter WAIT; WAIT SHALL capture and enter STREAM on the first edge with heap_data_v=1.
REQ-019 heap_clr SHALL be high for exactly the one cycle following the capture edge when CLR_AFTER_LOAD=1, and constantly 0 otherwise.
REQ-020 STREAM: out_valid SHALL be 1 from cycle N+1; out_data SHALL be snapshot[64*out_idx +: 64] (lane 4k in [15:0], lane 4k+3 in [63:48]).
REQ-021 A beat SHALL transfer only on out_valid && out_ready; out_idx then increments by 1.
REQ-022 While out_valid && !out_ready, out_data, out_idx, out_last SHALL hold unchanged.
REQ-023 out_last SHALL equal (out_idx == 15) while out_valid=1, else 0.
REQ-024 Handshake on beat 15 SHALL drop out_valid next cycle, enter DONE, raise done for one cycle, then return to IDLE; out_idx SHALL wrap to 0.
REQ-025 snap_req SHALL be ignored in WAIT, STREAM and DONE (no queuing); snap_req in IDLE the cycle after DONE SHALL be accepted normally.
REQ-026 busy SHALL be 1 in WAIT and STREAM, 0 in IDLE and DONE.
REQ-027 Minimum drain SHALL be 16 cycles with out_ready held 1; snapshot contents SHALL not change during a drain regardless of heap_data.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, out_valid=0, out_last=0, out_idx=0, out_data=0, heap_clr=0, busy=0, done=0, and snapshot=0.
REQ-029 Reset asserted mid-STREAM SHALL abort the drain with no done pulse; after release the block SHALL wait for a new snap_req.

Verification
REQ-030 Lane i = i+1, heap_data_v=1, snap_req pulse, out_ready=1 -> 16 beats, beat 0 = 0x0004_0003_0002_0001, beat 15 = 0x0040_003F_003E_003D with out_last, done at cycle N+17, heap_clr high in cycle N+1 only.
REQ-031 snap_req with heap_data_v=0 for 5 cycles then 1 -> busy high throughout, capture on the 6th edge, values as in REQ-030.
REQ-032 out_ready toggling 1,0,0,1 during stream -> out_data/out_idx hold across stalls; all 16 beats delivered in order, none duplicated or dropped.
REQ-033 CLR_AFTER_LOAD=0 -> heap_clr stays 0 for the whole drain; data identical to REQ-030.
REQ-034 rst=0 at beat 7 -> all outputs 0 same cycle, no done; new snap_req after release -> fresh drain from beat 0.
REQ-035 snap_req pulsed during STREAM and on the DONE cycle -> ignored; exactly one drain completes, one done pulse.
